sme_match_collector: RTL and testbench
======================================

// Module: sme_match_collector
// PURPOSE
//  - Sits directly downstream of the string matching engine. Consumes its per-match valid pulse with {pattern_no, match_addr}.
//  - Buffers each match record in a FIFO and presents it on a valid/ready output port.
//  - Keeps a saturating match count per pattern, readable through a select port.
//  - Raises all_done once the engine's finish is seen and the FIFO has drained.
// PARAMETERS
//  DEPTH   16  FIFO entries; must be a power of 2
//  AW      4   log2(DEPTH)
//  CNT_W   8   width of each per-pattern counter (16 counters, one per pattern_no)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous reset, ACTIVE-LOW (0 = reset)
//  m_valid       in   1   engine match pulse, 1 cycle per match
//  m_pattern_no  in   4   pattern index of the match
//  m_match_addr  in   12  text address of the match
//  m_finish      in   1   engine finished; level, held high until reset
//  o_valid       out  1   FIFO head record available
//  o_ready       in   1   downstream accepts the head when o_valid&o_ready
//  o_data        out  16  head record {pattern_no[3:0], match_addr[11:0]}
//  cnt_sel       in   4   pattern index to read
//  cnt_data      out  CNT_W  match count of pattern cnt_sel (combinational read)
//  overflow      out  1   sticky: a match was dropped because the FIFO was full
//  drop_cnt      out  8   dropped-match count, saturates at 255
//  all_done      out  1   finish seen and FIFO empty
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-operation):
//    - FIFO empties; pointers and occupancy go to 0.
//    - All counters, overflow, drop_cnt and all_done go to 0.
//    - o_valid=0, o_data=0. State goes to RUN.
//  - FIFO storage:
//    - wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
//    - occupancy is AW+1 bits, range 0..DEPTH.
//  - Push: occurs when m_valid=1 and the FIFO is not full. Record is written at wr_ptr at the clock edge.
//  - Pop: occurs when o_valid&o_ready. rd_ptr advances.
//  - o_valid = (occupancy!=0); o_data = mem[rd_ptr] (first-word-fall-through).
//  - Latency: a record pushed at edge N is visible on o_data/o_valid after edge N (next cycle). It does not bypass in the same cycle.
//  - Full and pop in the same cycle: the push is still accepted. Occupancy stays DEPTH; no drop occurs.
//  - Full with no pop: the match is dropped.
//    - overflow sets and holds until reset.
//    - drop_cnt increments, saturating at 255.
//    - The per-pattern counter still increments, so counts reflect every engine match.
//  - Empty and push in the same cycle: o_valid rises next cycle. A pop cannot occur that cycle.
//  - o_ready while o_valid=0: ignored.
//  - Per-pattern counters: on every m_valid in RUN, counter[m_pattern_no] increments, saturating at 2^CNT_W-1.
//  - State machine (2-bit):
//    - RUN:
//      - Accept matches.
//      - If m_finish=1 and m_valid=0: go to DRAIN.
//      - If m_finish=1 and m_valid=1: the match is processed normally this cycle, then go to DRAIN.
//    - DRAIN:
//      - m_valid is ignored (no push, no count).
//      - Pops continue.
//      - When occupancy==0: go to DONE.
//    - DONE:
//      - all_done=1 (registered; first high the cycle after the FIFO empties).
//      - Terminal until reset.
//      - o_valid=0; counters are frozen but still readable.
//  - If m_finish is high with the FIFO already empty, the path is RUN -> DRAIN -> DONE: all_done rises 2 cycles after m_finish is first sampled.
//  - match_addr is stored unmodified: no range check and no arithmetic on it.
// TESTING
//  - Reset pulse mid-stream with 5 records queued -> next cycle o_valid=0, cnt_data=0 for all sel, overflow=0.
//  - 3 matches (p0@0x005, p0@0x010, p2@0xFFF), o_ready=1 -> o_data 0x0005, 0x0010, 0x2FFF in order; cnt_sel=0 -> 2, cnt_sel=2 -> 1.
//  - o_ready=0, 18 matches of p1 -> occupancy 16, overflow=1, drop_cnt=2, cnt[1]=18; then drain 16 records in order.
//  - FIFO full, m_valid and o_ready in the same cycle -> occupancy stays 16, drop_cnt unchanged, new record emerges last.
//  - 300 matches of p3 with o_ready=1 -> cnt[3]=255 (saturated), drop_cnt=0.
//  - m_finish with 4 queued, o_ready toggling 1/0 -> all_done=0 until 4th pop, 1 the cycle after; a later m_valid is ignored.

Source files
------------

// File: rtl/sme_match_collector.sv
`default_nettype none
// ============================================================================
//  Module   : sme_match_collector
//  Purpose  : Collects string-matching-engine match records into a FWFT FIFO
//             with a valid/ready output. Keeps saturating per-pattern match
//             counts and a drop counter, and flags completion once the engine
//             has finished and the FIFO has drained.
//  Revision : 1.0 - initial release
// ============================================================================
module sme_match_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic             m_valid,
    input  logic [3:0]       m_pattern_no,
    input  logic [11:0]      m_match_addr,
    input  logic             m_finish,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [15:0]      o_data,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_data,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic             all_done
);

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [15:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occupancy;
    logic [CNT_W-1:0] counts [16];

    logic             running;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; only a full FIFO with no pop loses the record.
    assign running  = (state == ST_RUN);
    assign full     = (occupancy == OCC_FULL);
    assign o_valid  = (occupancy != '0) && (state != ST_DONE);
    assign pop      = o_valid & o_ready;
    assign push     = running & m_valid & (~full | pop);
    assign drop     = running & m_valid & full & ~pop;
    assign o_data   = o_valid ? mem[rd_ptr] : 16'h0000;
    assign cnt_data = counts[cnt_sel];

    // Record storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {m_pattern_no, m_match_addr};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Per-pattern counters count every engine match seen in RUN, dropped or not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                counts[i] <= '0;
            end
        end else if (running && m_valid && (counts[m_pattern_no] != '1)) begin
            counts[m_pattern_no] <= counts[m_pattern_no] + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // State register and registered completion flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            all_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            all_done <= (state_nxt == ST_DONE);
        end
    end

    // Next-state: finish moves to DRAIN (a coincident match is still taken),
    // DRAIN waits for the FIFO to empty, DONE is terminal until reset
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (m_finish)          state_nxt = ST_DRAIN;
            ST_DRAIN: if (occupancy == '0)   state_nxt = ST_DONE;
            ST_DONE:                         state_nxt = ST_DONE;
            default:                         state_nxt = ST_RUN;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sme_match_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sme_match_collector
//  Purpose  : Self-checking bench for sme_match_collector. A queue-based
//             reference model predicts accepted records (scoreboard), counts,
//             drops and completion; a monitor compares popped records.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sme_match_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_pattern_no = 4'd0;
    logic [11:0] m_match_addr = 12'd0;
    logic        m_finish = 1'b0;
    logic        o_ready = 1'b0;
    logic [3:0]  cnt_sel = 4'd0;
    wire         o_valid;
    wire  [15:0] o_data;
    wire  [7:0]  cnt_data;
    wire         overflow;
    wire  [7:0]  drop_cnt;
    wire         all_done;

    sme_match_collector #(.DEPTH(16), .AW(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_pattern_no (m_pattern_no),
        .m_match_addr (m_match_addr),
        .m_finish     (m_finish),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .cnt_sel      (cnt_sel),
        .cnt_data     (cnt_data),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .all_done     (all_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents as a queue, phase 0=run 1=drain 2=done
    logic [15:0] exp_q[$];
    logic [15:0] mfifo[$];
    int          mcnt[16];
    int          mdrop;
    int          movf;
    int          mphase;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        mfifo.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        mdrop  = 0;
        movf   = 0;
        mphase = 0;
    endtask

    // Asserts reset mid-cycle, checks the cleared outputs, releases after an edge
    task automatic do_reset();
        reset    = 1'b0;
        m_valid  = 1'b0;
        m_finish = 1'b0;
        o_ready  = 1'b0;
        model_reset();
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_all_done", all_done, 0);
        for (int s = 0; s < 16; s++) begin
            cnt_sel = 4'(s);
            #1;
            chk("rst_cnt_data", cnt_data, 0);
        end
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cnt_sel = 4'd0;
    endtask

    // Applies the current inputs for one clock edge to model and DUT, then checks
    task automatic tick();
        bit          pop;
        bit          acc;
        int          nph;
        logic [15:0] rec;
        pop = (mphase != 2) && (mfifo.size() > 0) && o_ready;
        acc = 1'b0;
        rec = {m_pattern_no, m_match_addr};
        nph = mphase;
        if (mphase == 0 && m_finish)               nph = 1;
        else if (mphase == 1 && mfifo.size() == 0) nph = 2;
        if (mphase == 0 && m_valid) begin
            if (mcnt[m_pattern_no] < 255) mcnt[m_pattern_no]++;
            if (mfifo.size() < 16 || pop) acc = 1'b1;
            else begin
                if (mdrop < 255) mdrop++;
                movf = 1;
            end
        end
        if (pop) void'(mfifo.pop_front());
        if (acc) begin
            mfifo.push_back(rec);
            exp_q.push_back(rec);
        end
        mphase = nph;
        @(posedge clk);
        #1;
        chk("o_valid", o_valid, int'(mphase != 2 && mfifo.size() != 0));
        chk("all_done", all_done, int'(mphase == 2));
        chk("overflow", overflow, movf);
        chk("drop_cnt", drop_cnt, mdrop);
        chk("cnt_data", cnt_data, mcnt[cnt_sel]);
    endtask

    task automatic send(input int p, input int a);
        m_valid      = 1'b1;
        m_pattern_no = 4'(p);
        m_match_addr = 12'(a);
        tick();
        m_valid = 1'b0;
    endtask

    // Monitor: every accepted handshake must pop the oldest predicted record
    always @(negedge clk) begin
        if (reset === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_pop", int'(o_data), -1);
            else                   chk("o_data", int'(o_data), int'(exp_q.pop_front()));
        end
    end

    // Stimulus
    initial begin
        model_reset();
        do_reset();

        // Three matches, streaming out in order
        o_ready = 1'b1;
        send(0, 12'h005);
        chk("first_head", o_data, 16'h0005);
        send(0, 12'h010);
        send(2, 12'hFFF);
        repeat (3) tick();
        cnt_sel = 4'd0; #1; chk("cnt_p0", cnt_data, 2);
        cnt_sel = 4'd2; #1; chk("cnt_p2", cnt_data, 1);

        // Overflow: 18 matches into a stalled FIFO, then drain
        do_reset();
        cnt_sel = 4'd1;
        for (int i = 0; i < 18; i++) send(1, 12'h100 + i);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_cnt, 2);
        chk("ovf_cnt_p1", cnt_data, 18);
        o_ready = 1'b1;
        repeat (17) tick();
        chk("ovf_drained", o_valid, 0);

        // Full FIFO with push and pop together: accepted, no drop
        o_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(5, 12'h200 + i);
        o_ready = 1'b1;
        send(6, 12'hABC);
        chk("fullpop_drops", drop_cnt, 2);
        repeat (17) tick();

        // Reset with five records queued
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 12'h300 + i);
        do_reset();

        // Counter saturation
        o_ready = 1'b1;
        cnt_sel = 4'd3;
        for (int i = 0; i < 300; i++) send(3, int'($urandom_range(0, 4095)));
        chk("sat_cnt_p3", cnt_data, 255);
        chk("sat_drops", drop_cnt, 0);
        repeat (2) tick();

        // Randomized traffic with back-pressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            m_valid      = ($urandom_range(0, 99) < 60);
            m_pattern_no = 4'($urandom_range(0, 15));
            m_match_addr = 12'($urandom_range(0, 4095));
            o_ready      = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80));
            cnt_sel      = 4'($urandom_range(0, 15));
            tick();
        end
        m_valid = 1'b0;
        o_ready = 1'b1;
        repeat (18) tick();

        // Finish with four queued, o_ready toggling; later matches ignored
        do_reset();
        for (int i = 0; i < 4; i++) send(7, 12'h400 + i);
        m_finish = 1'b1;
        for (int i = 0; i < 14; i++) begin
            o_ready = (i % 2 == 0);
            m_valid = (i > 9);
            m_pattern_no = 4'd7;
            cnt_sel = 4'd7;
            tick();
        end
        chk("fin_all_done", all_done, 1);
        chk("fin_cnt_p7", cnt_data, 4);

        // Finish with an empty FIFO: all_done two edges later
        do_reset();
        m_finish = 1'b1;
        tick();
        chk("efin_not_yet", all_done, 0);
        tick();
        chk("efin_done", all_done, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
